div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl.sv | 78 +++++++
 tb/tb_div_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle restoring divider for 32-bit DIV/DIVU
// FREE -> ON (33 clocks) or BYZERO -> END; result held while start_i stays high.
module div_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        annul_i,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   output logic [63:0] result_o,
   output logic        ready_o,
   output logic        stallreq_o
);
   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
   state_t state, nxt;
   logic [5:0] cnt;
   logic sgn, s1, s2;
   logic [31:0] dvs, rem, quo, rem_n;
   logic [32:0] sh;
   logic ge, accept, fin, hold;
   always_comb begin
      accept = state == FREE && start_i && !annul_i;
      fin = cnt == 6'd32;
      sh = {rem, quo[31]};
      ge = sh >= {1'b0, dvs};
      rem_n = ge ? sh[31:0] - dvs : sh[31:0];
      stallreq_o = start_i && !annul_i && state != END;
      nxt = state;
      case (state)
         FREE:    nxt = accept ? (opdata2_i == 32'd0 ? BYZERO : ON) : FREE;
         BYZERO:  nxt = annul_i ? FREE : END;
         ON:      nxt = annul_i ? FREE : (fin ? END : ON);
         default: nxt = (annul_i || !start_i) ? FREE : END;
      endcase
      hold = state == END && nxt == END;
   end
   always_ff @(posedge clk)
      state <= rst ? FREE : nxt;
   always_ff @(posedge clk)
      if (rst) begin
         cnt <= 6'd0;
         sgn <= 1'b0;
         s1 <= 1'b0;
         s2 <= 1'b0;
         dvs <= 32'd0;
         rem <= 32'd0;
         quo <= 32'd0;
         ready_o <= 1'b0;
         result_o <= 64'd0;
      end else begin
         ready_o <= hold;
         result_o <= hold ? {rem, quo} : 64'd0;
         if (accept) begin
            sgn <= signed_div_i;
            s1 <= opdata1_i[31];
            s2 <= opdata2_i[31];
            quo <= (signed_div_i && opdata1_i[31]) ? 32'd0 - opdata1_i : opdata1_i;
            dvs <= (signed_div_i && opdata2_i[31]) ? 32'd0 - opdata2_i : opdata2_i;
            rem <= 32'd0;
            cnt <= 6'd0;
         end else if (state == BYZERO) begin
            rem <= 32'd0;
            quo <= 32'd0;
         end else if (state == ON && !annul_i) begin
            // final ON clock restores signs instead of iterating
            if (fin) begin
               quo <= (sgn && (s1 ^ s2)) ? 32'd0 - quo : quo;
               rem <= (sgn && s1) ? 32'd0 - rem : rem;
               cnt <= 6'd0;
            end else begin
               rem <= rem_n;
               quo <= {quo[30:0], ge};
               cnt <= cnt + 6'd1;
            end
         end
      end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scenario tasks checked against an arithmetic model of DIV/DIVU
module tb_div_ctrl;
   logic clk = 1'b0;
   logic rst, start_i, annul_i, signed_div_i;
   logic [31:0] opdata1_i, opdata2_i;
   logic [63:0] result_o;
   logic ready_o, stallreq_o;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div_ctrl dut (
      .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
      .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
      .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
   );

   function automatic logic [63:0] model(bit sgn, logic [31:0] a, logic [31:0] b);
      longint q, r, sa, sb;
      if (b == 32'd0) return 64'd0;
      sa = sgn ? longint'($signed(a)) : longint'(a);
      sb = sgn ? longint'($signed(b)) : longint'(b);
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(bit sgn, logic [31:0] a, logic [31:0] b);
      signed_div_i = sgn;
      opdata1_i = a;
      opdata2_i = b;
      annul_i = 1'b0;
      start_i = 1'b1;
      tick();
   endtask

   task automatic wait_ready(bit scramble, output int lat);
      lat = -1;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (ready_o) begin
            lat = k;
            break;
         end
         if (scramble) begin
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            signed_div_i = 1'($urandom_range(0, 1));
            start_i = (k >= 30) || ($urandom_range(0, 3) != 0);
         end
      end
   endtask

   task automatic release_req;
      start_i = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      checks += 3;
      if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", ready_o); end
      if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result: got %h exp 0", result_o); end
      if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: got %b exp 0", stallreq_o); end
      start_i = 1'b1;
      #1;
      checks++;
      if (stallreq_o !== 1'b1) begin errors++; $display("FAIL reset_stall_req: got %b exp 1", stallreq_o); end
      start_i = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_unsigned_7_2;
      bit exp_stall;
      issue(1'b0, 32'd7, 32'd2);
      checks++;
      if (stallreq_o !== 1'b1) begin errors++; $display("FAIL u72_stall_k0: got %b exp 1", stallreq_o); end
      for (int k = 1; k <= 34; k++) begin
         tick();
         exp_stall = k < 33;
         checks += 2;
         if (stallreq_o !== exp_stall) begin errors++; $display("FAIL u72_stall k=%0d: got %b exp %b", k, stallreq_o, exp_stall); end
         if (ready_o !== (k == 34)) begin errors++; $display("FAIL u72_ready k=%0d: got %b exp %b", k, ready_o, k == 34); end
      end
      for (int h = 0; h < 3; h++) begin
         checks++;
         if (result_o !== 64'h00000001_00000003) begin errors++; $display("FAIL u72_result h=%0d: got %h exp 0000000100000003", h, result_o); end
         tick();
      end
      release_req();
      checks++;
      if (ready_o !== 1'b0 || result_o !== 64'd0) begin errors++; $display("FAIL u72_release: got ready=%b result=%h exp 0/0", ready_o, result_o); end
   endtask

   task automatic test_signed;
      int lat;
      issue(1'b1, 32'hFFFFFFF9, 32'h2);
      wait_ready(1'b0, lat);
      checks += 2;
      if (lat != 34) begin errors++; $display("FAIL s72_latency: got %0d exp 34", lat); end
      if (result_o !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL s72_result: got %h exp FFFFFFFFFFFFFFFD", result_o); end
      release_req();
   endtask

   task automatic test_corners;
      int lat;
      issue(1'b1, 32'h80000000, 32'hFFFFFFFF);
      wait_ready(1'b0, lat);
      checks += 2;
      if (lat != 34) begin errors++; $display("FAIL min_neg1_latency: got %0d exp 34", lat); end
      if (result_o !== 64'h00000000_80000000) begin errors++; $display("FAIL min_neg1_result: got %h exp 0000000080000000", result_o); end
      release_req();
      issue(1'b0, 32'hFFFFFFFF, 32'h1);
      wait_ready(1'b0, lat);
      checks += 2;
      if (lat != 34) begin errors++; $display("FAIL umax_1_latency: got %0d exp 34", lat); end
      if (result_o !== 64'h00000000_FFFFFFFF) begin errors++; $display("FAIL umax_1_result: got %h exp 00000000FFFFFFFF", result_o); end
      release_req();
   endtask

   task automatic test_zero;
      int lat;
      issue(1'b0, 32'd123, 32'd0);
      wait_ready(1'b0, lat);
      checks += 2;
      if (lat != 2) begin errors++; $display("FAIL zero_latency: got %0d exp 2", lat); end
      if (result_o !== 64'd0) begin errors++; $display("FAIL zero_result: got %h exp 0", result_o); end
      release_req();
      issue(1'b1, 32'hFFFF0000, 32'd0);
      wait_ready(1'b0, lat);
      checks += 2;
      if (lat != 2) begin errors++; $display("FAIL zero_s_latency: got %0d exp 2", lat); end
      if (result_o !== 64'd0) begin errors++; $display("FAIL zero_s_result: got %h exp 0", result_o); end
      release_req();
   endtask

   task automatic test_annul;
      int lat;
      bit seen;
      issue(1'b0, 32'd5000, 32'd3);
      repeat (10) tick();
      annul_i = 1'b1;
      start_i = 1'b0;
      #1;
      checks++;
      if (stallreq_o !== 1'b0) begin errors++; $display("FAIL annul_stall: got %b exp 0", stallreq_o); end
      tick();
      annul_i = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         seen |= ready_o;
         tick();
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL annul_no_ready: got ready seen=%b exp 0", seen); end
      issue(1'b0, 32'd100, 32'd7);
      wait_ready(1'b0, lat);
      checks += 2;
      if (lat != 34) begin errors++; $display("FAIL after_annul_latency: got %0d exp 34", lat); end
      if (result_o !== 64'h00000002_0000000E) begin errors++; $display("FAIL after_annul_result: got %h exp 000000020000000E", result_o); end
      release_req();
   endtask

   task automatic test_reset_mid;
      int lat;
      issue(1'b0, 32'd1000, 32'd3);
      repeat (20) tick();
      opdata1_i = 32'd99999;
      opdata2_i = 32'd17;
      rst = 1'b1;
      tick();
      checks += 3;
      if (ready_o !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b exp 0", ready_o); end
      if (result_o !== 64'd0) begin errors++; $display("FAIL rstmid_result: got %h exp 0", result_o); end
      if (stallreq_o !== 1'b1) begin errors++; $display("FAIL rstmid_stall: got %b exp 1", stallreq_o); end
      rst = 1'b0;
      tick();
      wait_ready(1'b0, lat);
      checks += 2;
      if (lat != 34) begin errors++; $display("FAIL rstmid_latency: got %0d exp 34", lat); end
      if (result_o !== model(1'b0, 32'd99999, 32'd17)) begin errors++; $display("FAIL rstmid_result2: got %h exp %h", result_o, model(1'b0, 32'd99999, 32'd17)); end
      release_req();
   endtask

   task automatic test_start_drop;
      int lat;
      logic [63:0] exp;
      exp = model(1'b1, 32'hFFFFCFC7, 32'd77);
      issue(1'b1, 32'hFFFFCFC7, 32'd77);
      repeat (5) tick();
      start_i = 1'b0;
      opdata1_i = 32'd1;
      opdata2_i = 32'd0;
      signed_div_i = 1'b0;
      repeat (10) tick();
      checks++;
      if (stallreq_o !== 1'b0) begin errors++; $display("FAIL drop_stall: got %b exp 0", stallreq_o); end
      start_i = 1'b1;
      wait_ready(1'b0, lat);
      checks += 2;
      if (lat + 15 != 34) begin errors++; $display("FAIL drop_latency: got %0d exp 34", lat + 15); end
      if (result_o !== exp) begin errors++; $display("FAIL drop_result: got %h exp %h", result_o, exp); end
      release_req();
   endtask

   task automatic test_random;
      int lat, sel;
      bit sgn;
      logic [31:0] a, b;
      logic [63:0] exp;
      for (int i = 0; i < 30; i++) begin
         sel = $urandom_range(0, 7);
         sgn = 1'($urandom_range(0, 1));
         a = (sel == 7) ? 32'h80000000 : $urandom;
         b = (sel == 0) ? 32'd0 : (sel < 4) ? 32'($urandom_range(1, 300)) : $urandom;
         if (sel == 7) b = $urandom_range(0, 1) ? 32'hFFFFFFFF : b;
         exp = model(sgn, a, b);
         issue(sgn, a, b);
         wait_ready(b != 32'd0, lat);
         checks += 3;
         if (lat != ((b == 32'd0) ? 2 : 34)) begin errors++; $display("FAIL rnd_latency i=%0d: got %0d exp %0d", i, lat, (b == 32'd0) ? 2 : 34); end
         if (result_o !== exp) begin errors++; $display("FAIL rnd_result i=%0d sgn=%b a=%h b=%h: got %h exp %h", i, sgn, a, b, result_o, exp); end
         release_req();
         if (ready_o !== 1'b0 || result_o !== 64'd0) begin errors++; $display("FAIL rnd_release i=%0d: got ready=%b result=%h exp 0/0", i, ready_o, result_o); end
      end
   endtask

   initial begin
      rst = 1'b1;
      start_i = 1'b0;
      annul_i = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i = 32'd0;
      opdata2_i = 32'd0;
      test_reset();
      test_unsigned_7_2();
      test_signed();
      test_corners();
      test_zero();
      test_annul();
      test_reset_mid();
      test_start_drop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
